skeleton_stim_sequencer: RTL

- Test sequencer placed directly upstream of the filter test skeleton on the device.
- Host writes samples into an input FIFO. The block pops each sample, presents it on the skeleton's DATA_IN and pulses its start trigger.
- It waits for the skeleton's RDY, then pushes the result into an output FIFO for host readback.
- Per-sample timeout and a processed-sample counter are included for on-device measurement runs.

---
 rtl/skeleton_stim_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/skeleton_stim_sequencer.sv
// Stimulus sequencer for the filter test skeleton: host input FIFO -> skeleton start/RDY handshake -> output FIFO.
// Define SEQ_LATENCY_MEAS_EN to add the LAT_LAST latency measurement output.
module skeleton_stim_sequencer #(
  parameter int BITWIDTH_SYS    = 16,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int TIMEOUT_CYC     = 1024
) (
  input  logic                    CLK_SYS,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    CLR_ERR,
  input  logic                    WR_EN,
  input  logic [BITWIDTH_SYS-1:0] WR_DATA,
  output logic                    WR_FULL,
  input  logic                    RD_EN,
  output logic [BITWIDTH_SYS-1:0] RD_DATA,
  output logic                    RD_EMPTY,
  output logic                    DUT_TRGG_START,
  output logic [BITWIDTH_SYS-1:0] DUT_DATA_IN,
  input  logic [BITWIDTH_SYS-1:0] DUT_DATA_OUT,
  input  logic                    DUT_RDY,
  output logic                    BUSY,
  output logic                    ERR_TIMEOUT,
  output logic [15:0]             SAMPLE_CNT
`ifdef SEQ_LATENCY_MEAS_EN
  ,
  output logic [15:0]             LAT_LAST
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_STORE} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [BITWIDTH_SYS-1:0] res_q, res_d;
  logic                    err_q, err_d;
  logic [15:0]             sample_cnt_q, sample_cnt_d;
  logic                    in_pop, out_push;

  // FIFO 0 is the host input FIFO, FIFO 1 the result FIFO read back by the host.
  logic [1:0]              push_v, pop_v, full_v, empty_v;
  logic [BITWIDTH_SYS-1:0] wdata_v [2];
  logic [BITWIDTH_SYS-1:0] rdata_v [2];

  assign push_v     = {out_push, WR_EN};
  assign pop_v      = {RD_EN, in_pop};
  assign wdata_v[0] = WR_DATA;
  assign wdata_v[1] = res_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [BITWIDTH_SYS-1:0] mem_q [DEPTH];
      logic [PW-1:0]           wptr_q, rptr_q;
      logic [CW-1:0]           fill_q;
      logic [BITWIDTH_SYS-1:0] rdata_q;
      logic                    do_push, do_pop;

      assign full_v[gi]  = (fill_q == CW'(DEPTH));
      assign empty_v[gi] = (fill_q == '0);
      assign do_pop      = pop_v[gi] && !empty_v[gi];
      // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
      assign do_push     = push_v[gi] && (!full_v[gi] || do_pop);
      assign rdata_v[gi] = rdata_q;

      always_ff @(posedge CLK_SYS) begin
        if (do_push) mem_q[wptr_q] <= wdata_v[gi];
      end

      always_ff @(posedge CLK_SYS or posedge RST) begin
        if (RST) begin
          wptr_q  <= '0;
          rptr_q  <= '0;
          fill_q  <= '0;
          rdata_q <= '0;
        end else begin
          if (do_push) wptr_q <= wptr_q + 1'b1;
          if (do_pop) begin
            rptr_q  <= rptr_q + 1'b1;
            rdata_q <= mem_q[rptr_q];
          end
          case ({do_push, do_pop})
            2'b10:   fill_q <= fill_q + 1'b1;
            2'b01:   fill_q <= fill_q - 1'b1;
            default: fill_q <= fill_q;
          endcase
        end
      end
    end
  endgenerate

`ifdef SEQ_LATENCY_MEAS_EN
  logic [15:0] lat_q, lat_d;
  logic [31:0] tmo_ext;
  assign tmo_ext = 32'(tmo_q);
`endif

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    res_d        = res_q;
    err_d        = err_q & ~CLR_ERR;
    sample_cnt_d = sample_cnt_q;
    in_pop       = 1'b0;
    out_push     = 1'b0;
`ifdef SEQ_LATENCY_MEAS_EN
    lat_d        = lat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (EN && !empty_v[0] && !full_v[1]) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_pop  = 1'b1;
        state_d = S_TRIG;
      end
      S_TRIG: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // RDY takes priority over a timeout landing in the same cycle.
        if (DUT_RDY) begin
          res_d   = DUT_DATA_OUT;
          state_d = S_STORE;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STORE: begin
        out_push     = 1'b1;
        sample_cnt_d = sample_cnt_q + 16'd1;
        state_d      = S_IDLE;
`ifdef SEQ_LATENCY_MEAS_EN
        // tmo_q now holds the number of WAIT cycles up to and including the RDY cycle.
        lat_d = (tmo_ext > 32'h0000_FFFF) ? 16'hFFFF : tmo_ext[15:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      sample_cnt_q <= '0;
`ifdef SEQ_LATENCY_MEAS_EN
      lat_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      res_q        <= res_d;
      err_q        <= err_d;
      sample_cnt_q <= sample_cnt_d;
`ifdef SEQ_LATENCY_MEAS_EN
      lat_q        <= lat_d;
`endif
    end
  end

  assign WR_FULL        = full_v[0];
  assign RD_EMPTY       = empty_v[1];
  assign RD_DATA        = rdata_v[1];
  assign DUT_DATA_IN    = rdata_v[0];
  assign DUT_TRGG_START = (state_q == S_TRIG);
  assign BUSY           = (state_q != S_IDLE);
  assign ERR_TIMEOUT    = err_q;
  assign SAMPLE_CNT     = sample_cnt_q;
`ifdef SEQ_LATENCY_MEAS_EN
  assign LAT_LAST       = lat_q;
`endif

endmodule
